// File: rtl/dummy_pkg.sv
// Shared types for the dummy coprocessor: ID width, issue mode and result mux select.
package dummy_pkg;

  localparam int unsigned XIdWidth = 4;

  // Execution class of a non-combinational instruction.
  typedef enum logic {
    MODE_PIPE = 1'b0,
    MODE_ITER = 1'b1
  } coproc_ctl_t;

  // Datapath result mux select.
  typedef enum logic [1:0] {
    RES_SEL_COMB = 2'd0,
    RES_SEL_PIPE = 2'd1,
    RES_SEL_ITER = 2'd2
  } res_sel_t;

endpackage

// File: rtl/dummy_ctl.sv
// dummy_ctl: issue/writeback sequencer for the dummy coprocessor datapath.
// Launches comb, pipelined or iterative instructions and keeps results in
// program order by only letting a class issue when no other class is in flight.
// Ports:
//   clk_i, rst_ni                      clock, async active-low reset
//   issue_valid_i/ready_o/id_i/mode_i/comb_i   instruction issue handshake
//   op_load_o                          operand register load (= issue handshake)
//   pipe_en_o                          pipelined-unit advance enable
//   iter_start_o/done_i/kill_o         iterative-unit control
//   flush_i                            synchronous flush of all in-flight work
//   res_valid_o/ready_i/id_o/sel_o     result handshake and datapath mux select
module dummy_ctl
  import dummy_pkg::*;
#(
  parameter int unsigned IdWidth   = dummy_pkg::XIdWidth,
  parameter int unsigned PipeDepth = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               issue_valid_i,
  output logic               issue_ready_o,
  input  logic [IdWidth-1:0] issue_id_i,
  input  logic               issue_mode_i,
  input  logic               issue_comb_i,
  output logic               op_load_o,
  output logic               pipe_en_o,
  output logic               iter_start_o,
  input  logic               iter_done_i,
  output logic               iter_kill_o,
  input  logic               flush_i,
  output logic               res_valid_o,
  input  logic               res_ready_i,
  output logic [IdWidth-1:0] res_id_o,
  output logic [1:0]         res_sel_o
);

  localparam int unsigned Last = PipeDepth - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PIPE,
    ST_COMB,
    ST_ITER,
    ST_ITER_RES
  } state_e;

  state_e                            state_q, state_d;
  logic [PipeDepth-1:0]              pvld_q, pvld_d;
  logic [PipeDepth-1:0][IdWidth-1:0] pid_q, pid_d;
  logic [IdWidth-1:0]                id_q, id_d;

  logic is_pipe;
  logic is_iter;

  assign is_pipe = !issue_comb_i && (issue_mode_i == MODE_PIPE);
  assign is_iter = !issue_comb_i && (issue_mode_i == MODE_ITER);

  // State register, pipe tracker and latched comb/iter ID.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      pvld_q  <= '0;
      pid_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      pvld_q  <= pvld_d;
      pid_q   <= pid_d;
      id_q    <= id_d;
    end
  end

  // Output decode; flush and reset override the per-state values.
  always_comb begin
    issue_ready_o = 1'b0;
    pipe_en_o     = 1'b1;
    res_valid_o   = 1'b0;
    res_id_o      = '0;
    res_sel_o     = RES_SEL_COMB;
    iter_kill_o   = 1'b0;
    case (state_q)
      ST_IDLE: issue_ready_o = 1'b1;
      ST_PIPE: begin
        // Stall the whole pipe while the head result is not taken.
        pipe_en_o     = !(pvld_q[Last] && !res_ready_i);
        issue_ready_o = pipe_en_o && is_pipe;
        res_valid_o   = pvld_q[Last];
        if (pvld_q[Last]) begin
          res_id_o  = pid_q[Last];
          res_sel_o = RES_SEL_PIPE;
        end
      end
      ST_COMB: begin
        res_valid_o = 1'b1;
        res_id_o    = id_q;
        res_sel_o   = RES_SEL_COMB;
      end
      ST_ITER_RES: begin
        res_valid_o = 1'b1;
        res_id_o    = id_q;
        res_sel_o   = RES_SEL_ITER;
      end
      default: ;
    endcase
    if (flush_i) begin
      issue_ready_o = 1'b0;
      res_valid_o   = 1'b0;
      res_id_o      = '0;
      res_sel_o     = RES_SEL_COMB;
      iter_kill_o   = (state_q == ST_ITER);
    end
    // Nothing is accepted or pulsed while reset is held.
    if (!rst_ni) begin
      issue_ready_o = 1'b0;
      iter_kill_o   = 1'b0;
    end
  end

  assign op_load_o    = issue_valid_i && issue_ready_o;
  assign iter_start_o = op_load_o && is_iter;

  // Next-state and tracker update.
  always_comb begin
    state_d = state_q;
    pvld_d  = pvld_q;
    pid_d   = pid_q;
    id_d    = id_q;
    if (flush_i) begin
      state_d = ST_IDLE;
      pvld_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (op_load_o) begin
            if (issue_comb_i) begin
              id_d    = issue_id_i;
              state_d = ST_COMB;
            end else if (is_iter) begin
              id_d    = issue_id_i;
              state_d = ST_ITER;
            end else begin
              pvld_d[0] = 1'b1;
              pid_d[0]  = issue_id_i;
              state_d   = ST_PIPE;
            end
          end
        end
        ST_PIPE: begin
          if (pipe_en_o) begin
            for (int unsigned i = 1; i < PipeDepth; i++) begin
              pvld_d[i] = pvld_q[i-1];
              pid_d[i]  = pid_q[i-1];
            end
            // Stage 0 takes the new issue or a bubble.
            pvld_d[0] = op_load_o;
            pid_d[0]  = issue_id_i;
          end
          if (pvld_d == '0) state_d = ST_IDLE;
        end
        ST_COMB:     if (res_ready_i) state_d = ST_IDLE;
        ST_ITER:     if (iter_done_i) state_d = ST_ITER_RES;
        ST_ITER_RES: if (res_ready_i) state_d = ST_IDLE;
        default:     state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dummy_ctl.sv
// Directed, table-driven bench for dummy_ctl (IdWidth=4, PipeDepth=3).
module tb_dummy_ctl;

  localparam int unsigned IdW   = 4;
  localparam int unsigned Depth = 3;

  localparam int P  = 0;   // pipe mode
  localparam int I  = 1;   // iter mode
  localparam int SC = 0;   // comb select
  localparam int SP = 1;   // pipe select
  localparam int SI = 2;   // iter select

  logic           clk;
  logic           rst_n;
  logic           issue_valid;
  logic           issue_ready;
  logic [IdW-1:0] issue_id;
  logic           issue_mode;
  logic           issue_comb;
  logic           op_load;
  logic           pipe_en;
  logic           iter_start;
  logic           iter_done;
  logic           iter_kill;
  logic           flush;
  logic           res_valid;
  logic           res_ready;
  logic [IdW-1:0] res_id;
  logic [1:0]     res_sel;

  dummy_ctl #(.IdWidth(IdW), .PipeDepth(Depth)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .issue_valid_i(issue_valid),
    .issue_ready_o(issue_ready),
    .issue_id_i   (issue_id),
    .issue_mode_i (issue_mode),
    .issue_comb_i (issue_comb),
    .op_load_o    (op_load),
    .pipe_en_o    (pipe_en),
    .iter_start_o (iter_start),
    .iter_done_i  (iter_done),
    .iter_kill_o  (iter_kill),
    .flush_i      (flush),
    .res_valid_o  (res_valid),
    .res_ready_i  (res_ready),
    .res_id_o     (res_id),
    .res_sel_o    (res_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the expected outputs for that cycle.
  typedef struct {
    int          sc;
    logic        v;
    logic [3:0]  id;
    logic        mode;
    logic        comb;
    logic        done;
    logic        flush;
    logic        rr;
    logic [11:0] exp;   // {ready, load, pipe_en, start, kill, rvalid, rid[3:0], rsel[1:0]}
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   cur_sc = 0;

  function automatic logic [11:0] ex(input int rdy, input int ld, input int en, input int st,
                                     input int kl, input int rv, input int rid, input int sel);
    return {1'(rdy), 1'(ld), 1'(en), 1'(st), 1'(kl), 1'(rv), 4'(rid), 2'(sel)};
  endfunction

  function automatic void add(input int v, input int id, input int mode, input int comb,
                              input int done, input int fl, input int rr, input logic [11:0] e);
    vec_t t;
    t.sc    = cur_sc;
    t.v     = 1'(v);
    t.id    = 4'(id);
    t.mode  = 1'(mode);
    t.comb  = 1'(comb);
    t.done  = 1'(done);
    t.flush = 1'(fl);
    t.rr    = 1'(rr);
    t.exp   = e;
    vecs.push_back(t);
  endfunction

  function automatic logic [11:0] sample();
    return {issue_ready, op_load, pipe_en, iter_start, iter_kill, res_valid, res_id, res_sel};
  endfunction

  task automatic drive(input vec_t t);
    issue_valid = t.v;
    issue_id    = t.id;
    issue_mode  = t.mode;
    issue_comb  = t.comb;
    iter_done   = t.done;
    flush       = t.flush;
    res_ready   = t.rr;
  endtask

  task automatic check(input string name, input int idx, input logic [11:0] want);
    logic [11:0] got;
    got = sample();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s #%0d: got rdy%b ld%b en%b st%b kl%b rv%b id%0d sel%0d, want rdy%b ld%b en%b st%b kl%b rv%b id%0d sel%0d",
               name, idx, got[11], got[10], got[9], got[8], got[7], got[6], got[5:2], got[1:0],
               want[11], want[10], want[9], want[8], want[7], want[6], want[5:2], want[1:0]);
    end
  endtask

  initial begin
    vec_t z;
    z.sc = 0; z.v = 1'b1; z.id = 4'd5; z.mode = 1'b0; z.comb = 1'b1;
    z.done = 1'b1; z.flush = 1'b1; z.rr = 1'b1; z.exp = '0;

    // Reset held with busy inputs: everything at reset values.
    rst_n = 1'b0;
    drive(z);
    #12;
    check("reset_hold", 0, ex(0, 0, 1, 0, 0, 0, 0, SC));
    @(negedge clk);
    check("reset_hold", 1, ex(0, 0, 1, 0, 0, 0, 0, SC));
    z.v = 1'b0; z.done = 1'b0; z.flush = 1'b0; z.rr = 1'b0; z.comb = 1'b0;
    drive(z);
    rst_n = 1'b1;

    // Scenario 1: comb ID 5, held until taken, then comb ID 6.
    cur_sc = 1;
    add(1, 5, P, 1, 0, 0, 0, ex(1, 1, 1, 0, 0, 0, 0, SC));
    add(0, 0, P, 0, 0, 0, 0, ex(0, 0, 1, 0, 0, 1, 5, SC));
    add(1, 6, P, 1, 0, 0, 1, ex(0, 0, 1, 0, 0, 1, 5, SC));
    add(1, 6, P, 1, 0, 0, 0, ex(1, 1, 1, 0, 0, 0, 0, SC));
    add(0, 0, P, 0, 0, 0, 1, ex(0, 0, 1, 0, 0, 1, 6, SC));
    add(0, 0, P, 0, 0, 0, 1, ex(1, 0, 1, 0, 0, 0, 0, SC));

    // Scenario 2: pipe streaming 1..4, results on cycles 3..6.
    cur_sc = 2;
    for (int k = 1; k <= 4; k++) add(1, k, P, 0, 0, 0, 1, ex(1, 1, 1, 0, 0, (k == 4) ? 1 : 0, (k == 4) ? 1 : 0, (k == 4) ? SP : SC));
    for (int k = 2; k <= 4; k++) add(0, 0, P, 0, 0, 0, 1, ex(1, 0, 1, 0, 0, 1, k, SP));
    add(0, 0, P, 0, 0, 0, 1, ex(1, 0, 1, 0, 0, 0, 0, SC));

    // Scenario 3: same stream, result stalled on cycles 3-4.
    cur_sc = 3;
    for (int k = 1; k <= 3; k++) add(1, k, P, 0, 0, 0, 1, ex(1, 1, 1, 0, 0, 0, 0, SC));
    add(1, 4, P, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 1, SP));
    add(1, 4, P, 0, 0, 0, 0, ex(0, 0, 0, 0, 0, 1, 1, SP));
    add(1, 4, P, 0, 0, 0, 1, ex(1, 1, 1, 0, 0, 1, 1, SP));
    for (int k = 2; k <= 4; k++) add(0, 0, P, 0, 0, 0, 1, ex(1, 0, 1, 0, 0, 1, k, SP));
    add(0, 0, P, 0, 0, 0, 1, ex(1, 0, 1, 0, 0, 0, 0, SC));

    // Scenario 4: ordering, comb ID 2 waits for pipe ID 1 to write back.
    cur_sc = 4;
    add(1, 1, P, 0, 0, 0, 1, ex(1, 1, 1, 0, 0, 0, 0, SC));
    add(1, 2, P, 1, 0, 0, 1, ex(0, 0, 1, 0, 0, 0, 0, SC));
    add(1, 2, P, 1, 0, 0, 1, ex(0, 0, 1, 0, 0, 0, 0, SC));
    add(1, 2, P, 1, 0, 0, 1, ex(0, 0, 1, 0, 0, 1, 1, SP));
    add(1, 2, P, 1, 0, 0, 1, ex(1, 1, 1, 0, 0, 0, 0, SC));
    add(0, 0, P, 0, 0, 0, 1, ex(0, 0, 1, 0, 0, 1, 2, SC));
    add(0, 0, P, 0, 0, 0, 1, ex(1, 0, 1, 0, 0, 0, 0, SC));

    // Scenario 5: iter ID 9, done 10 cycles after start, issue offered throughout.
    cur_sc = 5;
    add(1, 9, I, 0, 0, 0, 0, ex(1, 1, 1, 1, 0, 0, 0, SC));
    for (int k = 1; k <= 10; k++) add(1, 3, P, 1, (k == 10) ? 1 : 0, 0, 0, ex(0, 0, 1, 0, 0, 0, 0, SC));
    add(0, 0, P, 0, 0, 0, 0, ex(0, 0, 1, 0, 0, 1, 9, SI));
    add(0, 0, P, 0, 0, 0, 1, ex(0, 0, 1, 0, 0, 1, 9, SI));
    add(0, 0, P, 0, 0, 0, 0, ex(1, 0, 1, 0, 0, 0, 0, SC));

    // Scenario 6: flush with two pipe ops in flight; no result ever appears.
    cur_sc = 6;
    add(1, 1, P, 0, 0, 0, 1, ex(1, 1, 1, 0, 0, 0, 0, SC));
    add(1, 2, P, 0, 0, 0, 1, ex(1, 1, 1, 0, 0, 0, 0, SC));
    add(1, 3, P, 0, 0, 1, 1, ex(0, 0, 1, 0, 0, 0, 0, SC));
    for (int k = 0; k < 4; k++) add(0, 0, P, 0, 0, 0, 1, ex(1, 0, 1, 0, 0, 0, 0, SC));

    // Scenario 7: flush during ITER kills it; a late done is ignored.
    cur_sc = 7;
    add(1, 7, I, 0, 0, 0, 1, ex(1, 1, 1, 1, 0, 0, 0, SC));
    add(0, 0, P, 0, 0, 0, 1, ex(0, 0, 1, 0, 0, 0, 0, SC));
    add(0, 0, P, 0, 0, 1, 1, ex(0, 0, 1, 0, 1, 0, 0, SC));
    add(0, 0, P, 0, 1, 0, 1, ex(1, 0, 1, 0, 0, 0, 0, SC));
    add(0, 0, P, 0, 0, 0, 1, ex(1, 0, 1, 0, 0, 0, 0, SC));

    // Scenario 8: flush while a comb result waits drops it.
    cur_sc = 8;
    add(1, 4, P, 1, 0, 0, 0, ex(1, 1, 1, 0, 0, 0, 0, SC));
    add(0, 0, P, 0, 0, 1, 1, ex(0, 0, 1, 0, 0, 0, 0, SC));
    add(0, 0, P, 0, 0, 0, 1, ex(1, 0, 1, 0, 0, 0, 0, SC));

    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n]);
      #1;
      check($sformatf("vec_sc%0d", vecs[n].sc), n, vecs[n].exp);
    end

    // Reset mid-iteration: work discarded, no kill pulse, done afterwards ignored.
    z.v = 1'b1; z.id = 4'd8; z.mode = 1'b1; z.comb = 1'b0; z.flush = 1'b0; z.done = 1'b0; z.rr = 1'b0;
    @(negedge clk);
    drive(z);
    #1;
    check("midop_issue", 0, ex(1, 1, 1, 1, 0, 0, 0, SC));
    @(negedge clk);
    z.v = 1'b0; z.flush = 1'b1;
    drive(z);
    rst_n = 1'b0;
    #1;
    check("midop_reset", 0, ex(0, 0, 1, 0, 0, 0, 0, SC));
    @(negedge clk);
    z.flush = 1'b0; z.done = 1'b1;
    drive(z);
    rst_n = 1'b1;
    #1;
    check("midop_after", 0, ex(1, 0, 1, 0, 0, 0, 0, SC));
    @(negedge clk);
    z.done = 1'b0; z.rr = 1'b1;
    drive(z);
    #1;
    check("midop_after", 1, ex(1, 0, 1, 0, 0, 0, 0, SC));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
